// File: rtl/fetch_unit_if.sv
// Instruction-memory fetch bus between the fetch stage and instruction memory.
// The fetch stage is the master: it raises imem_req with imem_addr and waits
// for the memory to return imem_rdata qualified by imem_ack.
interface fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction-fetch stage of the multi-cycle CPU.
// Holds the PC, selects the next PC from PCSrc/PCWre, runs one req/ack fetch
// per accepted IRWre, latches the instruction register and freezes on the
// halt opcode (6'b111111) until reset.
// Optional build macro FETCH_PERF_CNT_EN adds a 32-bit fetch_count output
// counting accepted acks.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        PCWre,
  input  logic [1:0]  PCSrc,
  input  logic        IRWre,
  input  logic [31:0] imm_ext,
  input  logic [31:0] rs_data,
  fetch_unit_if.master imem,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic [31:0] ir,
  output logic [5:0]  op,
  output logic        ir_valid,
  output logic        fetch_busy,
  output logic        halted
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] fetch_count
`endif
);

  localparam logic [5:0] HALT_OP = 6'b111111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_REQ  = 2'b01,
    ST_HALT = 2'b10
  } state_t;

  state_t      state_r, state_n;
  logic [31:0] pc_r, pc_n;
  logic [31:0] addr_r, addr_n;
  logic [31:0] ir_r, ir_n;
  logic        valid_r, valid_n;
  logic        req_r, req_n;
  logic        busy_r, busy_n;
  logic        halted_r, halted_n;
  logic [31:0] pc_plus4_s;
  logic [31:0] next_pc_s;
  logic        ack_take_s;

  assign pc_plus4_s = pc_r + 32'd4;
  // An ack only counts while a request is outstanding.
  assign ack_take_s = (state_r == ST_REQ) && imem.imem_ack;

  // Next-PC selection; all arithmetic wraps modulo 2^32.
  always_comb begin
    next_pc_s = pc_plus4_s;
    case (PCSrc)
      2'b00:   next_pc_s = pc_plus4_s;
      2'b01:   next_pc_s = pc_plus4_s + {imm_ext[29:0], 2'b00};
      2'b10:   next_pc_s = rs_data;
      2'b11:   next_pc_s = {pc_plus4_s[31:28], ir_r[25:0], 2'b00};
      default: next_pc_s = pc_plus4_s;
    endcase
  end

  // Next-state and next-register logic for the IDLE/REQ/HALT controller.
  always_comb begin
    state_n  = state_r;
    pc_n     = pc_r;
    addr_n   = addr_r;
    ir_n     = ir_r;
    valid_n  = valid_r;
    req_n    = req_r;
    busy_n   = busy_r;
    halted_n = halted_r;
    case (state_r)
      ST_IDLE: begin
        if (PCWre) begin
          pc_n    = next_pc_s;
          valid_n = 1'b0;
        end else begin
          pc_n = pc_r;
        end
        if (IRWre) begin
          // A same-edge commit fetches from the PC being committed.
          addr_n  = PCWre ? next_pc_s : pc_r;
          req_n   = 1'b1;
          busy_n  = 1'b1;
          valid_n = 1'b0;
          state_n = ST_REQ;
        end else begin
          state_n = ST_IDLE;
        end
      end
      ST_REQ: begin
        // PCWre and IRWre are ignored here so the PC stays put across a fetch.
        if (imem.imem_ack) begin
          ir_n    = imem.imem_rdata;
          valid_n = 1'b1;
          req_n   = 1'b0;
          busy_n  = 1'b0;
          if (imem.imem_rdata[31:26] == HALT_OP) begin
            state_n  = ST_HALT;
            halted_n = 1'b1;
          end else begin
            state_n = ST_IDLE;
          end
        end else begin
          state_n = ST_REQ;
        end
      end
      ST_HALT: begin
        halted_n = 1'b1;
        state_n  = ST_HALT;
      end
      default: begin
        state_n = ST_IDLE;
        req_n   = 1'b0;
        busy_n  = 1'b0;
      end
    endcase
  end

  // Controller state register.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_n;
    end
  end

  // Datapath and registered-output registers.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      pc_r     <= RESET_PC;
      addr_r   <= RESET_PC;
      ir_r     <= 32'h0000_0000;
      valid_r  <= 1'b0;
      req_r    <= 1'b0;
      busy_r   <= 1'b0;
      halted_r <= 1'b0;
    end else begin
      pc_r     <= pc_n;
      addr_r   <= addr_n;
      ir_r     <= ir_n;
      valid_r  <= valid_n;
      req_r    <= req_n;
      busy_r   <= busy_n;
      halted_r <= halted_n;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] count_r;

  // Counts accepted acks; naturally frozen in HALT since no ack is taken there.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      count_r <= 32'h0000_0000;
    end else if (ack_take_s) begin
      count_r <= count_r + 32'd1;
    end else begin
      count_r <= count_r;
    end
  end

  assign fetch_count = count_r;
`endif

  assign imem.imem_req  = req_r;
  assign imem.imem_addr = addr_r;
  assign pc             = pc_r;
  assign pc_plus4       = pc_plus4_s;
  assign ir             = ir_r;
  assign op             = ir_r[31:26];
  assign ir_valid       = valid_r;
  assign fetch_busy     = busy_r;
  assign halted         = halted_r;

  // ack_take_s is only consumed by the optional counter.
  logic unused_s;
  assign unused_s = ack_take_s;

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: stimulus pushes expected fetch addresses
// and fetched words into queues; a monitor compares them when imem_req rises
// and when ir_valid rises. A small memory responder acks after a set delay.
module tb_fetch_unit;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        PCWre = 1'b0;
  logic        IRWre = 1'b0;
  logic [1:0]  PCSrc = 2'b00;
  logic [31:0] imm_ext = 32'hFFFF_FFFE;
  logic [31:0] rs_data = 32'h0000_0000;
  logic [31:0] pc, pc_plus4, ir;
  logic [5:0]  op;
  logic        ir_valid, fetch_busy, halted;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_count;
`endif

  fetch_unit_if mif();

  fetch_unit dut (
    .CLK        (CLK),
    .RST        (RST),
    .PCWre      (PCWre),
    .PCSrc      (PCSrc),
    .IRWre      (IRWre),
    .imm_ext    (imm_ext),
    .rs_data    (rs_data),
    .imem       (mif),
    .pc         (pc),
    .pc_plus4   (pc_plus4),
    .ir         (ir),
    .op         (op),
    .ir_valid   (ir_valid),
    .fetch_busy (fetch_busy),
    .halted     (halted)
`ifdef FETCH_PERF_CNT_EN
    ,
    .fetch_count(fetch_count)
`endif
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [31:0] word;
    int          waitn;
  } ir_exp_t;

  int          checks = 0;
  int          failures = 0;
  logic [31:0] addr_q[$];
  ir_exp_t     ir_q[$];
  logic [31:0] mem_word = 32'h0;
  int          wait_n = 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic commit(input logic [1:0] src);
    PCSrc = src;
    PCWre = 1'b1;
    tick();
    PCWre = 1'b0;
  endtask

  task automatic setpc(input logic [31:0] v);
    rs_data = v;
    commit(2'b10);
  endtask

  task automatic start_fetch(input logic [31:0] exp_addr, input logic [31:0] word,
                             input int wn, input logic with_pc);
    ir_exp_t e;
    mem_word = word;
    wait_n   = wn;
    addr_q.push_back(exp_addr);
    e.word  = word;
    e.waitn = wn;
    ir_q.push_back(e);
    PCSrc = 2'b00;
    PCWre = with_pc;
    IRWre = 1'b1;
    tick();
    IRWre = 1'b0;
    PCWre = 1'b0;
  endtask

  task automatic wait_fetch(input string name);
    int n;
    n = 0;
    while (!ir_valid && n < 50) begin
      tick();
      n++;
    end
    if (!ir_valid) begin
      checks++;
      failures++;
      $display("FAIL %s_timeout got=ir_valid_low exp=ir_valid_high", name);
    end
    tick();
  endtask

  // Memory responder: ack after wait_n cycles of an outstanding request.
  initial begin
    int cnt;
    cnt = 0;
    mif.imem_ack   = 1'b0;
    mif.imem_rdata = 32'h0;
    forever begin
      @(negedge CLK);
      if (mif.imem_req) begin
        cnt++;
        if (cnt >= wait_n) begin
          mif.imem_ack   = 1'b1;
          mif.imem_rdata = mem_word;
        end else begin
          mif.imem_ack = 1'b0;
        end
      end else begin
        cnt = 0;
        mif.imem_ack = 1'b0;
      end
    end
  end

  // Monitor: compare request address and fetched instruction against queues.
  initial begin
    logic    pr, pv;
    int      bc;
    ir_exp_t e;
    pr = 1'b0;
    pv = 1'b0;
    bc = 0;
    forever begin
      @(negedge CLK);
      if (mif.imem_req && !pr) begin
        bc = 0;
        if (addr_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_req got=%h exp=no_request", mif.imem_addr);
        end else begin
          chk("fetch_addr", mif.imem_addr, addr_q.pop_front());
        end
      end
      if (fetch_busy) bc++;
      if (ir_valid && !pv) begin
        if (ir_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_ir got=%h exp=no_fetch", ir);
        end else begin
          e = ir_q.pop_front();
          chk("ir", ir, e.word);
          chk("op", {26'd0, op}, {26'd0, e.word[31:26]});
          chk("busy_cycles", 32'(bc), 32'(e.waitn));
        end
      end
      pr = mif.imem_req;
      pv = ir_valid;
    end
  end

  // Global time bound.
  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  // Directed stimulus.
  initial begin
    #12;
    chk("rst_pc", pc, 32'h0);
    chk("rst_addr", mif.imem_addr, 32'h0);
    chk("rst_pc_plus4", pc_plus4, 32'h4);
    chk("rst_ir", ir, 32'h0);
    chk("rst_op", {26'd0, op}, 32'h0);
    chk("rst_flags", {28'd0, ir_valid, mif.imem_req, fetch_busy, halted}, 32'h0);
`ifdef FETCH_PERF_CNT_EN
    chk("rst_count", fetch_count, 32'h0);
`endif
    tick();
    RST = 1'b1;
    tick();

    // Reset fetch: 3 busy cycles, instruction 0x0800_0010.
    start_fetch(32'h0, 32'h0800_0010, 3, 1'b0);
    wait_fetch("reset_fetch");
    chk("rf_ir_valid", {31'd0, ir_valid}, 32'h1);
    chk("rf_op", {26'd0, op}, 32'h2);
    chk("rf_pc", pc, 32'h0);

    // Next-PC select from pc=0x100.
    setpc(32'h100);
    chk("jr_pc", pc, 32'h100);
    chk("pc_plus4", pc_plus4, 32'h104);
    chk("valid_cleared", {31'd0, ir_valid}, 32'h0);
    commit(2'b00);
    chk("seq_pc", pc, 32'h104);
    setpc(32'h100);
    commit(2'b01);
    chk("branch_pc", pc, 32'hFC);
    setpc(32'h100);
    rs_data = 32'h40;
    commit(2'b10);
    chk("jr40_pc", pc, 32'h40);
    setpc(32'h100);
    commit(2'b11);
    chk("jump_pc", pc, 32'h40);

    // Same-edge commit and fetch from pc=8.
    setpc(32'h8);
    start_fetch(32'hC, 32'h2000_0005, 2, 1'b1);
    wait_fetch("same_edge");
    chk("se_pc", pc, 32'hC);

    // Stall: PCWre/IRWre during REQ are ignored.
    start_fetch(32'hC, 32'h8C00_0004, 4, 1'b0);
    PCSrc = 2'b00;
    PCWre = 1'b1;
    IRWre = 1'b1;
    tick();
    tick();
    PCWre = 1'b0;
    IRWre = 1'b0;
    chk("stall_pc", pc, 32'hC);
    chk("stall_addr", mif.imem_addr, 32'hC);
    chk("stall_busy", {31'd0, fetch_busy}, 32'h1);
    wait_fetch("stall");
    tick();
    tick();
    chk("stall_no_req", {31'd0, mif.imem_req}, 32'h0);
    chk("stall_pc_after", pc, 32'hC);

    // Wrap.
    setpc(32'hFFFF_FFFC);
    chk("wrap_plus4", pc_plus4, 32'h0);
    commit(2'b00);
    chk("wrap_pc", pc, 32'h0);
    start_fetch(32'h0, 32'h0000_0020, 1, 1'b0);
    wait_fetch("fetch4");
    start_fetch(32'h0, 32'h1000_0001, 2, 1'b0);
    wait_fetch("fetch5");
`ifdef FETCH_PERF_CNT_EN
    chk("count5", fetch_count, 32'd5);
`endif

    // Reset mid-REQ drops the request immediately and discards the ack.
    start_fetch(32'h0, 32'h1234_5678, 5, 1'b0);
    tick();
    chk("mid_req_high", {31'd0, mif.imem_req}, 32'h1);
    #2;
    RST = 1'b0;
    #1;
    chk("mid_req_low", {31'd0, mif.imem_req}, 32'h0);
    chk("mid_busy_low", {31'd0, fetch_busy}, 32'h0);
    chk("mid_ir", ir, 32'h0);
`ifdef FETCH_PERF_CNT_EN
    chk("mid_count", fetch_count, 32'h0);
`endif
    ir_q.delete(ir_q.size() - 1);
    tick();
    tick();
    RST = 1'b1;
    tick();
    tick();
    tick();
    chk("mid_valid_after", {31'd0, ir_valid}, 32'h0);
    chk("mid_ir_after", ir, 32'h0);

    // Halt.
    start_fetch(32'h0, 32'hFC00_0000, 2, 1'b0);
    wait_fetch("halt");
    chk("halted", {31'd0, halted}, 32'h1);
    PCSrc = 2'b01;
    PCWre = 1'b1;
    tick();
    PCWre = 1'b0;
    IRWre = 1'b1;
    tick();
    IRWre = 1'b0;
    tick();
    tick();
    chk("halt_pc", pc, 32'h0);
    chk("halt_ir", ir, 32'hFC00_0000);
    chk("halt_no_req", {31'd0, mif.imem_req}, 32'h0);
    chk("halt_hold", {31'd0, halted}, 32'h1);
`ifdef FETCH_PERF_CNT_EN
    chk("halt_count", fetch_count, 32'h1);
`endif
    RST = 1'b0;
    #1;
    chk("halt_cleared", {31'd0, halted}, 32'h0);
    tick();
    RST = 1'b1;
    tick();

    chk("addr_q_empty", 32'(addr_q.size()), 32'h0);
    chk("ir_q_empty", 32'(ir_q.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage of the multi-cycle CPU, directly upstream of the control unit. Holds the program counter, selects the next PC from the control unit's `PCSrc`/`PCWre` outputs, runs a req/ack fetch against instruction memory when `IRWre` is pulsed, and latches the instruction register whose opcode field feeds the control unit's `Op` input. Also detects `halt` and freezes the stage.

## Interface

**Parameters**
- `RESET_PC`, default `32'h0000_0000`: PC value after reset.

**Ports**
- `CLK` in 1: single clock, rising edge.
- `RST` in 1: reset, asynchronous, active-low.
- `PCWre` in 1: commit next PC this edge.
- `PCSrc` in 2: next-PC select. `00` = PC+4, `01` = branch, `10` = jr, `11` = jump.
- `IRWre` in 1: start a fetch at the current PC.
- `imm_ext` in 32: extended immediate, used as the branch offset.
- `rs_data` in 32: register value, used as the jr target.
- `imem_req` out 1: fetch request.
- `imem_addr` out 32: fetch address.
- `imem_ack` in 1: fetch data valid.
- `imem_rdata` in 32: fetched word.
- `pc` out 32: current PC.
- `pc_plus4` out 32: PC+4, used as the jal link value.
- `ir` out 32: instruction register.
- `op` out 6: `ir[31:26]`.
- `ir_valid` out 1: `ir` holds a fetched, unconsumed instruction.
- `fetch_busy` out 1: fetch in flight; the control unit must hold state.
- `halted` out 1: halt opcode fetched.

## Operation

**Next-PC arithmetic** (all 32-bit, modulo 2^32)
- `pc_plus4` = `pc + 4`.
- `01` (branch): `pc_plus4 + (imm_ext << 2)`.
- `10` (jr): `rs_data`.
- `11` (jump): `{pc_plus4[31:28], ir[25:0], 2'b00}`.

**State machine:** IDLE, REQ, HALT.
- **IDLE**
  - `IRWre`=1: capture the fetch address, go to REQ.
  - The fetch address is the next PC if `PCWre`=1 on the same edge, else `pc`.
- **REQ**
  - `imem_req`=1 and `fetch_busy`=1. `imem_addr` holds the captured address.
  - On an edge with `imem_ack`=1: `ir` <= `imem_rdata`, `ir_valid` <= 1, `imem_req` <= 0.
  - Next state is HALT if `imem_rdata[31:26]`==`6'b111111`, else IDLE.
- **HALT**
  - `halted`=1.
  - `PCWre` and `IRWre` are ignored; `pc` and `ir` are frozen.
  - Left only by reset.

**PC update**
- `pc` <= next PC on a rising edge with `PCWre`=1, in IDLE only.
- `PCWre` is ignored in REQ, so the PC stays stable across a fetch.

**ir_valid**
- Set on ack.
- Cleared on an accepted `PCWre` or an accepted `IRWre`.
- Set has priority when ack and a clear fall on the same edge; this can only happen with `PCWre`, which is already ignored in REQ.

**Other rules**
- `IRWre` in REQ or HALT is ignored. It is not queued.
- `imem_ack` outside REQ is ignored.

## Timing

**Reset values**
- `pc`=`RESET_PC`, `imem_addr`=`RESET_PC`, `pc_plus4`=`RESET_PC`+4.
- `ir`=0, `op`=0, `ir_valid`=0, `imem_req`=0, `fetch_busy`=0, `halted`=0.
- State = IDLE.

**Latency**
- `imem_req` rises on the edge after `IRWre` is sampled.
- `ir` is updated on the same edge that samples `imem_ack`. Minimum fetch is 2 cycles (ack held high).

**Outputs**
- `pc_plus4` and `op` are combinational from their registers.
- All other outputs are registered.

**Boundaries**
- PC+4 from `32'hFFFF_FFFC` wraps to `32'h0`.
- A negative branch offset wraps modulo 2^32.
- Reset asserted mid-fetch drops `imem_req` asynchronously and discards the pending ack.

## Configuration

- **`FETCH_PERF_CNT_EN` defined**
  - Adds output `fetch_count` (out, 32 bits), reset to 0.
  - Increments on each accepted ack, wrapping at 2^32.
  - Frozen in HALT.
- **Undefined:** the port and counter are absent. All other behaviour is identical.

## Test plan

- **Reset fetch:** release `RST`, pulse `IRWre`, ack 3 cycles later with `32'h0800_0010`.
  - `imem_addr`=0, `ir`=`32'h0800_0010`, `op`=`6'b000010`, `ir_valid`=1, `fetch_busy` high for 3 cycles.
- **Next-PC select:** `pc`=`32'h0000_0100`, `imm_ext`=`32'hFFFF_FFFE`, `rs_data`=`32'h0000_0040`, `ir[25:0]`=`26'h10`.
  - `PCSrc`=00 gives `pc`=`32'h104`.
  - `PCSrc`=01 gives `pc`=`32'hFC`.
  - `PCSrc`=10 gives `pc`=`32'h40`.
  - `PCSrc`=11 gives `pc`=`32'h40`.
- **Stall:** `PCWre`=1 and a second `IRWre` asserted during REQ.
  - `pc` unchanged, `imem_addr` unchanged, only one ack consumed.
- **Same-edge commit and fetch:** `PCWre`=1, `PCSrc`=00, `IRWre`=1 in IDLE with `pc`=`32'h8`.
  - `imem_addr`=`32'hC`.
- **Halt:** fetch `32'hFC00_0000`.
  - `halted`=1. Later `PCWre`/`IRWre` pulses leave `pc` and `ir` unchanged until `RST` is low.
- **Wrap and counter:** `pc`=`32'hFFFF_FFFC`, `PCSrc`=00.
  - `pc`=0.
  - With `FETCH_PERF_CNT_EN`, after 5 fetches `fetch_count`=5.
  - Reset mid-REQ gives `fetch_count`=0 and `imem_req`=0 immediately.
